uart_rx: RTL and testbench

- Serial receive stage that feeds the simpleio register block.
- Oversamples the asynchronous `rxd` line, frames 8N1 characters and presents each byte on an AXI-stream-style valid/ready output.
- Reports busy, frame-error and overrun status.
- Bit timing comes from the 16-bit prescaler register in simpleio; one bit time is `prescale*8` clocks.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_sync_bit.sv | 45 ++++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module      : uart_pkg
// Description : Shared definitions for the UART receive/transmit blocks:
//               receiver state encoding, oversampling ratio, bit-timer
//               width and the bit-timer reload helper.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  // Bit-timer ticks per bit, in units of the prescaler period
  localparam int OVERSAMPLE         = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;
  // 16-bit prescaler times 8 fits in 19 bits
  localparam int TIMER_W            = 19;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Reload value for the down-counting bit timer: a full bit or half a bit,
  // minus one because the sample point is the cycle the counter hits zero.
  function automatic logic [TIMER_W-1:0] bit_ticks(input logic [15:0] prescale,
                                                   input logic        half);
    logic [TIMER_W-1:0] w_full;
    w_full    = TIMER_W'(prescale) * TIMER_W'(OVERSAMPLE);
    bit_ticks = (half ? (w_full >> 1) : w_full) - TIMER_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync_bit.sv
//------------------------------------------------------------------------------
// Module      : sync_bit
// Description : Multi-flop synchroniser for a single asynchronous input.
//               Flops reset to 1 so an idle-high line is not misread as
//               active while reset is released.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (STAGES <= 1) begin : g_single
      logic r_sync;

      // Single capture flop
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= 1'b1;
        else     r_sync <= d;
      end

      assign q = r_sync;
    end else begin : g_multi
      logic [STAGES-1:0] r_sync;

      // Shift chain; the oldest stage is the synchronised output
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[STAGES-2:0], d};
      end

      assign q = r_sync[STAGES-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// Module      : uart_rx
// Description : 8N1 UART receiver with prescaled oversampling, AXI-stream
//               style byte output, busy / frame-error / overrun status.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           prescale,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  rx_busy,
  output logic                  rx_overrun_error,
  output logic                  rx_frame_error
);

  localparam int                 c_BIT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);

  logic                  w_rxs;
  logic                  w_sample;

  rx_state_t             r_state;
  logic [TIMER_W-1:0]    r_timer;
  logic [c_BIT_W-1:0]    r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  // Cleared by a framing error so a line stuck low is not taken as a new start
  logic                  r_armed;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_busy;
  logic                  r_overrun;
  logic                  r_frame_err;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync_rxd (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (w_rxs)
  );

  assign w_sample = (r_timer == '0);

  // Receiver FSM, bit timer, shift register and output/status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RX_IDLE;
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_armed     <= 1'b1;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;

      // Consumer handshake; a same-cycle completion below takes priority
      if (r_tvalid && output_axis_tready) begin
        r_tvalid <= 1'b0;
      end

      case (r_state)
        RX_IDLE: begin
          if (w_rxs) begin
            r_armed <= 1'b1;
          end
          if ((prescale != 16'd0) && r_armed && !w_rxs) begin
            r_timer <= bit_ticks(prescale, 1'b1);
            r_state <= RX_START;
            r_busy  <= 1'b1;
          end
        end

        RX_START: begin
          if (!w_sample) begin
            r_timer <= r_timer - TIMER_W'(1);
          end else if (!w_rxs) begin
            r_timer   <= bit_ticks(prescale, 1'b0);
            r_bit_idx <= '0;
            r_state   <= RX_DATA;
          end else begin
            // Line went back high before mid-start: treat as a glitch
            r_state <= RX_IDLE;
            r_busy  <= 1'b0;
          end
        end

        RX_DATA: begin
          if (!w_sample) begin
            r_timer <= r_timer - TIMER_W'(1);
          end else begin
            r_shift <= {w_rxs, r_shift[DATA_WIDTH-1:1]};
            r_timer <= bit_ticks(prescale, 1'b0);
            if (r_bit_idx == c_LAST_BIT) begin
              r_state <= RX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + c_BIT_W'(1);
            end
          end
        end

        RX_STOP: begin
          if (!w_sample) begin
            r_timer <= r_timer - TIMER_W'(1);
          end else begin
            r_state <= RX_IDLE;
            r_busy  <= 1'b0;
            if (w_rxs) begin
              r_tdata   <= r_shift;
              r_tvalid  <= 1'b1;
              r_overrun <= r_tvalid && !output_axis_tready;
            end else begin
              r_frame_err <= 1'b1;
              r_armed     <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= RX_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign output_axis_tdata  = r_tdata;
  assign output_axis_tvalid = r_tvalid;
  assign rx_busy            = r_busy;
  assign rx_overrun_error   = r_overrun;
  assign rx_frame_error     = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. A driver serialises frames
//               and pushes the expected outcome into a scoreboard; a monitor
//               pops and compares whenever the DUT reports a byte or error.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

  logic        clk;
  logic        rst;
  logic [15:0] prescale;
  logic        rxd;
  logic [7:0]  output_axis_tdata;
  logic        output_axis_tvalid;
  logic        output_axis_tready;
  logic        rx_busy;
  logic        rx_overrun_error;
  logic        rx_frame_error;

  typedef struct {
    logic [7:0] data;
    bit         ovr;
    bit         fe;
  } exp_t;

  exp_t sb[$];

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  pending = 0;      // model: a delivered byte has not been consumed yet
  bit  prev_tvalid = 0;
  bit  busy_seen = 0;
  int  fe_seen = 0;
  int  ovr_seen = 0;
  time t_start = 0;
  time t_rise = 0;

  uart_rx #(
    .DATA_WIDTH  (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .prescale           (prescale),
    .rxd                (rxd),
    .output_axis_tdata  (output_axis_tdata),
    .output_axis_tvalid (output_axis_tvalid),
    .output_axis_tready (output_axis_tready),
    .rx_busy            (rx_busy),
    .rx_overrun_error   (rx_overrun_error),
    .rx_frame_error     (rx_frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Serialise one 8N1 frame; the expected outcome comes from the line rules:
  // disabled receiver -> nothing, low stop bit -> frame error, otherwise a byte
  // that overruns when the previous one is still held unconsumed.
  task automatic send_frame(input logic [7:0] data, input bit stop_ok,
                            input int cpb, input int gap);
    if (prescale != 16'd0) begin
      if (!stop_ok) begin
        sb.push_back('{data: data, ovr: 1'b0, fe: 1'b1});
      end else begin
        sb.push_back('{data: data, ovr: (pending && !output_axis_tready), fe: 1'b0});
        pending = !output_axis_tready;
      end
    end
    @(negedge clk);
    rxd     = 1'b0;
    t_start = $time;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (cpb) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (cpb) @(negedge clk);
    rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Monitor: compare every reported byte / error against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rx_busy) busy_seen = 1;
      if (rx_frame_error) fe_seen++;
      if (rx_overrun_error) ovr_seen++;
      if (output_axis_tvalid && !prev_tvalid) t_rise = $time;
      if ((output_axis_tvalid && !prev_tvalid) || rx_overrun_error) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte", output_axis_tdata);
        end else begin
          e = sb.pop_front();
          check("byte_not_frame_error", {31'd0, e.fe}, 32'd0);
          check("byte_data", {24'd0, output_axis_tdata}, {24'd0, e.data});
          check("byte_overrun_flag", {31'd0, rx_overrun_error}, {31'd0, e.ovr});
        end
      end
      if (rx_frame_error) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame_error: got 1 expected 0");
        end else begin
          e = sb.pop_front();
          check("frame_error_expected", {31'd0, e.fe}, 32'd1);
        end
      end
    end
    prev_tvalid = output_axis_tvalid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] rd;
    int p;

    rst = 1'b1;
    prescale = 16'd4;
    rxd = 1'b1;
    output_axis_tready = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset defaults
    check("rst_tdata", {24'd0, output_axis_tdata}, 32'd0);
    check("rst_tvalid", {31'd0, output_axis_tvalid}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_overrun", {31'd0, rx_overrun_error}, 32'd0);
    check("rst_frame_err", {31'd0, rx_frame_error}, 32'd0);

    // Reset in the middle of a 0xA5 frame aborts it
    rd = 8'hA5;
    rxd = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = rd[i];
      repeat (32) @(negedge clk);
    end
    check("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("busy_cleared_by_rst", {31'd0, rx_busy}, 32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check("no_valid_after_abort", {31'd0, output_axis_tvalid}, 32'd0);

    // Single byte, held until accepted; latency 307 +/- 1 clocks
    output_axis_tready = 1'b0;
    send_frame(8'h55, 1'b1, 32, 64);
    lat = int'((t_rise - t_start) / 10);
    n_tests++;
    if (lat < 306 || lat > 308) begin
      n_fail++;
      $display("FAIL latency: got %0d clocks expected 307 +/- 1", lat);
    end
    check("single_tvalid_held", {31'd0, output_axis_tvalid}, 32'd1);
    check("single_tdata", {24'd0, output_axis_tdata}, 32'h55);
    output_axis_tready = 1'b1;
    pending = 0;
    @(negedge clk);
    output_axis_tready = 1'b0;
    check("accept_clears_tvalid", {31'd0, output_axis_tvalid}, 32'd0);

    // Glitch rejection
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    rxd = 1'b1;
    check("glitch_busy_during", {31'd0, rx_busy}, 32'd1);
    repeat (20) @(negedge clk);
    check("glitch_busy_dropped", {31'd0, rx_busy}, 32'd0);
    check("glitch_no_valid", {31'd0, output_axis_tvalid}, 32'd0);

    // Frame error, then a good byte
    output_axis_tready = 1'b1;
    fe_seen = 0;
    send_frame(8'h3C, 1'b0, 32, 64);
    check("frame_error_pulse_count", fe_seen, 32'd1);
    check("frame_error_no_valid", {31'd0, output_axis_tvalid}, 32'd0);
    send_frame(8'h81, 1'b1, 32, 64);
    check("after_fe_tdata", {24'd0, output_axis_tdata}, 32'h81);

    // Overrun: two back-to-back bytes with nobody consuming
    output_axis_tready = 1'b0;
    ovr_seen = 0;
    send_frame(8'h12, 1'b1, 32, 8);
    send_frame(8'h34, 1'b1, 32, 32);
    check("overrun_pulse_count", ovr_seen, 32'd1);
    check("overrun_tdata", {24'd0, output_axis_tdata}, 32'h34);
    check("overrun_tvalid", {31'd0, output_axis_tvalid}, 32'd1);
    output_axis_tready = 1'b1;
    pending = 0;
    @(negedge clk);

    // Disabled receiver, then P=1
    prescale = 16'd0;
    busy_seen = 0;
    send_frame(8'hFF, 1'b1, 32, 32);
    check("disabled_busy_never", {31'd0, busy_seen}, 32'd0);
    check("disabled_no_valid", {31'd0, output_axis_tvalid}, 32'd0);
    prescale = 16'd1;
    send_frame(8'h0F, 1'b1, 8, 16);
    check("p1_tdata", {24'd0, output_axis_tdata}, 32'h0F);

    // Randomised frames: data, prescale, stop bit and consumer readiness
    for (int n = 0; n < 14; n++) begin
      p = int'($urandom_range(1, 3));
      prescale = 16'(p);
      output_axis_tready = 1'($urandom % 2);
      if (output_axis_tready) pending = 0;
      send_frame(8'($urandom), (($urandom % 5) != 0), p * 8, p * 16);
    end
    output_axis_tready = 1'b1;
    repeat (4) @(negedge clk);

    check("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
